// File: rtl/sram_bist_master.sv
// March-style BIST initiator for the user side of a ready-paced SRAM controller.
// Runs four phases WR0/RD0/WR1/RD1 over addresses 0..LAST_ADDR, then reports
// pass/fail, the first failing address and a saturating error count.
module sram_bist_master #(
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned LAST_ADDR = 2**18-1,
  parameter logic [DATA_W-1:0] SEED = DATA_W'(16'hA5A5),
  parameter int unsigned ERR_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] err_addr,
  output logic              mem,
  output logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_f2s,
  input  logic              ready,
  input  logic [DATA_W-1:0] data_s2f
);

  typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, DRAIN, DONE} state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   addr_d, exp_addr, exp_addr_d, chk_addr, chk_addr_d, err_addr_d;
  logic [DATA_W-1:0]   data_d, exp_data, exp_data_d, chk_data, chk_data_d;
  logic [ERR_W-1:0]    err_count_d;
  logic                mem_d, rw_d, busy_d, done_d, pass_d;
  logic                rd_pend, rd_pend_d, chk, chk_d;
  logic                accept, rd_accept, last;

  // Phase pattern: address folded to data width, XOR seed, optionally inverted.
  function automatic logic [DATA_W-1:0] pattern(input logic inv, input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] p;
    p = DATA_W'(a) ^ SEED;
    return inv ? ~p : p;
  endfunction

  // State and output registers; reset aborts any test in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem       <= 1'b0;
      rw        <= 1'b1;
      addr      <= '0;
      data_f2s  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      err_addr  <= '0;
      rd_pend   <= 1'b0;
      exp_data  <= '0;
      exp_addr  <= '0;
      chk       <= 1'b0;
      chk_data  <= '0;
      chk_addr  <= '0;
    end else begin
      state     <= state_d;
      mem       <= mem_d;
      rw        <= rw_d;
      addr      <= addr_d;
      data_f2s  <= data_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      err_count <= err_count_d;
      err_addr  <= err_addr_d;
      rd_pend   <= rd_pend_d;
      exp_data  <= exp_data_d;
      exp_addr  <= exp_addr_d;
      chk       <= chk_d;
      chk_data  <= chk_data_d;
      chk_addr  <= chk_addr_d;
    end
  end

  // Next-state, command issue, read-check pipeline and error bookkeeping.
  always_comb begin
    state_d     = state;
    mem_d       = mem;
    rw_d        = rw;
    addr_d      = addr;
    data_d      = data_f2s;
    busy_d      = busy;
    done_d      = done;
    pass_d      = pass;
    err_count_d = err_count;
    err_addr_d  = err_addr;
    rd_pend_d   = rd_pend;
    exp_data_d  = exp_data;
    exp_addr_d  = exp_addr;
    chk_d       = 1'b0;
    chk_data_d  = chk_data;
    chk_addr_d  = chk_addr;
    accept      = ready && mem;
    rd_accept   = accept && rw;
    last        = (addr == ADDR_W'(LAST_ADDR));

    // Compare stage: data_s2f holds the read result during the chk cycle.
    if (chk && (data_s2f != chk_data)) begin
      if (err_count != '1) err_count_d = err_count + ERR_W'(1);
      if (err_count == '0) err_addr_d = chk_addr;
    end

    // The ready edge after a read acceptance is when read data lands.
    if (ready && rd_pend) begin
      chk_d      = 1'b1;
      chk_data_d = exp_data;
      chk_addr_d = exp_addr;
      rd_pend_d  = 1'b0;
    end

    // A read accepted on that same edge re-arms the pending slot.
    if (rd_accept) begin
      rd_pend_d  = 1'b1;
      exp_data_d = pattern(state == RD1, addr);
      exp_addr_d = addr;
    end

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d     = WR0;
          mem_d       = 1'b1;
          rw_d        = 1'b0;
          addr_d      = '0;
          data_d      = pattern(1'b0, '0);
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_count_d = '0;
          err_addr_d  = '0;
        end
      end
      WR0, RD0, WR1, RD1: begin
        if (accept) begin
          if (last) begin
            addr_d = '0;
            case (state)
              WR0: begin
                state_d = RD0;
                rw_d    = 1'b1;
                data_d  = '0;
              end
              RD0: begin
                state_d = WR1;
                rw_d    = 1'b0;
                data_d  = pattern(1'b1, '0);
              end
              WR1: begin
                state_d = RD1;
                rw_d    = 1'b1;
                data_d  = '0;
              end
              default: begin
                state_d = DRAIN;
                mem_d   = 1'b0;
                rw_d    = 1'b1;
                data_d  = '0;
              end
            endcase
          end else begin
            addr_d = addr + ADDR_W'(1);
            data_d = rw ? '0 : pattern(state == WR1, addr + ADDR_W'(1));
          end
        end
      end
      DRAIN: begin
        // Finish once the final read's compare cycle is under way.
        if (chk && !rd_pend) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_d == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
